// File: rtl/data_mem_responder_pkg.sv
// Shared opcode constants, FSM state encoding and request legality check
// for the data-memory responder.
package data_mem_responder_pkg;

    localparam logic [3:0] WE_LOAD = 4'b0000;
    localparam logic [3:0] WE_BYTE = 4'b0001;
    localparam logic [3:0] WE_HALF = 4'b0011;
    localparam logic [3:0] WE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    // Opcode/alignment legality only; the depth check lives in the top level.
    function automatic logic we_illegal(input logic [3:0] we, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (we)
            WE_LOAD, WE_BYTE: bad = 1'b0;
            WE_HALF:          bad = (offset == 2'd3);
            WE_WORD:          bad = (offset != 2'd0);
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Single-port word array with per-byte write enables and a registered read,
// shaped so synthesis maps it onto block RAM.
module dmem_word_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Variable-latency data-memory target: latches one request, waits WAIT_CYCLES,
// performs a lane-aligned array access and holds the response until taken.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_we,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_byte_sel,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [AW-1:0] word_reg;
    logic [1:0]    sel_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    mask_reg;
    logic          load_reg;
    logic          err_reg;

    logic          accept;
    logic          range_err;
    logic          req_err;
    logic [3:0]    lane_mask;
    logic [31:0]   lane_data;
    logic [31:0]   arr_rdata;

    assign accept    = req_valid && (state_reg == IDLE);
    assign range_err = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
    assign req_err   = range_err || we_illegal(req_we, req_addr[1:0]);

    always_comb begin
        lane_mask = req_we << req_addr[1:0];
        lane_data = req_wdata << {req_addr[1:0], 3'b000};
        if (req_we == WE_WORD) begin
            lane_mask = req_we;
            lane_data = req_wdata;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ACCESS;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ACCESS;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            word_reg  <= '0;
            sel_reg   <= '0;
            wdata_reg <= '0;
            mask_reg  <= '0;
            load_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                word_reg  <= req_addr[AW+1:2];
                sel_reg   <= req_addr[1:0];
                wdata_reg <= lane_data;
                mask_reg  <= lane_mask;
                load_reg  <= (req_we == WE_LOAD);
                err_reg   <= req_err;
            end
        end
    end

    // Erroneous requests still read (harmlessly) but never write.
    dmem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .en   (state_reg == ACCESS),
        .we   ((state_reg == ACCESS && !err_reg) ? mask_reg : 4'b0000),
        .addr (word_reg),
        .wdata(wdata_reg),
        .rdata(arr_rdata)
    );

    assign req_ready    = (state_reg == IDLE);
    assign rsp_valid    = (state_reg == RESP);
    assign rsp_rdata    = (rsp_valid && load_reg && !err_reg) ? arr_rdata : 32'h0;
    assign rsp_byte_sel = rsp_valid ? sel_reg : 2'b00;
    assign rsp_err      = rsp_valid && err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder against a byte-addressed
// reference memory model.
module tb_data_mem_responder;

    localparam int DEPTH  = 256;
    localparam int W      = 2;
    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_we = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_byte_sel;
    logic        rsp_err;

    always #(PERIOD/2) clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_we      (req_we),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_byte_sel(rsp_byte_sel),
        .rsp_err     (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  sel;
        logic        err;
        longint      t_acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem_m [0:4*DEPTH-1];
    int         checks = 0;
    int         errors = 0;
    int         hold_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: byte-addressed memory, stores of 1/2/4 bytes starting at the byte address.
    function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                                  output logic [31:0] rd, output logic err);
        int unsigned off, widx, base, nbytes;
        off  = a % 4;
        widx = a / 4;
        err  = (widx >= DEPTH);
        rd   = 32'h0;
        nbytes = 0;
        case (we)
            4'b0000: nbytes = 0;
            4'b0001: nbytes = 1;
            4'b0011: begin nbytes = 2; if (off == 3) err = 1'b1; end
            4'b1111: begin nbytes = 4; if (off != 0) err = 1'b1; end
            default: err = 1'b1;
        endcase
        if (!err) begin
            base = widx * 4;
            if (we == 4'b0000) begin
                rd = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
            end else begin
                for (int i = 0; i < nbytes; i++) mem_m[a+i] = d[8*i +: 8];
            end
        end
    endfunction

    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                          input bit track);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_we    = we;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=ready_low required=ready_high addr=%h", a);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (track) begin
            model(a, d, we, e.rdata, e.err);
            e.sel   = a[1:0];
            e.t_acc = $time;
            sb.push_back(e);
        end
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_we    = 4'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (hold_cnt > 0) begin
            rsp_ready = 1'b0;
            hold_cnt--;
        end else begin
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    logic        prev_valid = 1'b0;
    logic        prev_take = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic [1:0]  prev_sel = '0;
    logic        prev_err = 1'b0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_take  = 1'b0;
        end else begin
            if (prev_take) begin
                check("release_req_ready", 32'(req_ready), 32'd1);
                check("release_rsp_valid", 32'(rsp_valid), 32'd0);
            end
            if (rsp_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=rsp_valid required=no_response at t=%0t", $time);
                end else begin
                    check("latency", 32'($time - PERIOD/2 - sb[0].t_acc), 32'((W+1)*PERIOD));
                end
            end
            if (rsp_valid) check("req_ready_in_resp", 32'(req_ready), 32'd0);
            if (rsp_valid && prev_valid) begin
                check("stable_rdata", rsp_rdata, prev_rdata);
                check("stable_sel", 32'(rsp_byte_sel), 32'(prev_sel));
                check("stable_err", 32'(rsp_err), 32'(prev_err));
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_byte_sel", 32'(rsp_byte_sel), 32'(mon_e.sel));
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                $display("rsp rdata=%h sel=%0d err=%0b", rsp_rdata, rsp_byte_sel, rsp_err);
            end
            prev_valid = rsp_valid;
            prev_rdata = rsp_rdata;
            prev_sel   = rsp_byte_sel;
            prev_err   = rsp_err;
            prev_take  = rsp_valid && rsp_ready;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  we;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_sel", 32'(rsp_byte_sel), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        for (int w = 0; w < DEPTH; w++) do_req(32'(w * 4), $urandom, 4'hF, 1'b1);

        do_req(32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        do_req(32'h10, 32'h0, 4'h0, 1'b1);
        do_req(32'h20, 32'h0, 4'hF, 1'b1);
        do_req(32'h22, 32'h000000AB, 4'h1, 1'b1);
        do_req(32'h20, 32'h0, 4'h0, 1'b1);
        do_req(32'h13, 32'h0000CAFE, 4'h3, 1'b1);
        do_req(32'h10, 32'h0, 4'h0, 1'b1);
        do_req(32'(DEPTH * 4), 32'h1234, 4'hF, 1'b1);
        do_req(32'h24, 32'h5555, 4'b0101, 1'b1);

        wait_idle();
        hold_cnt = 9;
        do_req(32'h22, 32'h0, 4'h0, 1'b1);
        wait_idle();

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 7))
                0:       a = $urandom;
                1:       a = 32'((DEPTH + $urandom_range(0, 3)) * 4 + $urandom_range(0, 3));
                default: a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2: we = 4'b0000;
                3, 4:    we = 4'b0001;
                5, 6:    we = 4'b0011;
                7, 8:    we = 4'b1111;
                default: we = 4'($urandom_range(0, 15));
            endcase
            do_req(a, $urandom, we, 1'b1);
        end

        wait_idle();
        do_req(32'h40, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midwait_reset_ready", 32'(req_ready), 32'd1);
        check("midwait_reset_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        do_req(32'h10, 32'h0, 4'h0, 1'b1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
